fetch_ref_line_packer: RTL and testbench

//   Fill stage in front of the fetch reference line buffer (128 lines x 512 bit, single-port).

---
 rtl/fetch_ref_line_packer.sv | 147 ++++++++++++++
 tb/tb_fetch_ref_line_packer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ref_line_packer.sv
// Packs BEATS input beats into one line and writes it to the fetch reference line buffer.
// A line write waits in WRITE while the reader holds the shared single RAM port.
module fetch_ref_line_packer #(
  parameter int BEAT_W = 128,
  parameter int BEATS  = 4,
  parameter int ADDR_W = 7
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start_i,
  input  logic [ADDR_W-1:0]       base_addr_i,
  input  logic [7:0]              num_lines_i,
  input  logic                    in_valid_i,
  input  logic [BEAT_W-1:0]       in_data_i,
  output logic                    in_ready_o,
  input  logic                    stall_i,
  output logic                    wrif_en_o,
  output logic [ADDR_W-1:0]       wrif_addr_o,
  output logic [BEAT_W*BEATS-1:0] wrif_data_o,
  output logic                    busy_o,
  output logic                    done_o
);

  localparam int LINE_W = BEAT_W * BEATS;
  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          lines_q, lines_d;
  logic [BCNT_W-1:0]   beat_q, beat_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic                done_q, done_d;

  logic beat_acc;
  logic wr_fire;
  logic last_line;
  logic start_idle;
  logic fill_go;
  logic fill_empty;

  assign start_idle = (state_q == IDLE) && start_i;
  assign fill_go    = start_idle && (num_lines_i != 8'd0);
  assign fill_empty = start_idle && (num_lines_i == 8'd0);
  assign beat_acc   = (state_q == LOAD) && in_valid_i;
  assign wr_fire    = (state_q == WRITE) && !stall_i;
  assign last_line  = (lines_q == 8'd1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (fill_go) state_d = LOAD;
      LOAD:    if (beat_acc && (beat_q == LAST_BEAT)) state_d = WRITE;
      WRITE:   if (wr_fire) state_d = last_line ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o = 1'b0;
    wrif_en_o  = 1'b0;
    busy_o     = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy_o = 1'b0;
      end
      LOAD: begin
        in_ready_o = 1'b1;
        busy_o     = 1'b1;
      end
      WRITE: begin
        wrif_en_o = ~stall_i;
        busy_o    = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Beat k of a line lands in bits [k*BEAT_W +: BEAT_W]; the first beat fills the LSBs.
  always_comb begin
    addr_d  = addr_q;
    lines_d = lines_q;
    beat_d  = beat_q;
    line_d  = line_q;
    done_d  = 1'b0;

    if (start_idle) begin
      addr_d  = base_addr_i;
      lines_d = num_lines_i;
      beat_d  = '0;
      done_d  = fill_empty;
    end

    if (beat_acc) begin
      for (int b = 0; b < BEATS; b++) begin
        if (beat_q == BCNT_W'(b)) begin
          line_d[b*BEAT_W +: BEAT_W] = in_data_i;
        end
      end
      beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end

    // Address wraps naturally at the top of the line buffer.
    if (wr_fire) begin
      addr_d  = addr_q + 1'b1;
      lines_d = lines_q - 8'd1;
      done_d  = last_line;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q  <= '0;
      lines_q <= '0;
      beat_q  <= '0;
      line_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      lines_q <= lines_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      done_q  <= done_d;
    end
  end

  assign wrif_addr_o = addr_q;
  assign wrif_data_o = line_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_fetch_ref_line_packer.sv
// Directed bench for fetch_ref_line_packer: table of fills plus reset-mid-fill sequence.
module tb_fetch_ref_line_packer;

  localparam int BEAT_W = 128;
  localparam int BEATS  = 4;
  localparam int ADDR_W = 7;
  localparam int LINE_W = BEAT_W * BEATS;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start_i = 1'b0;
  logic [ADDR_W-1:0] base_addr_i = '0;
  logic [7:0]        num_lines_i = '0;
  logic              in_valid_i = 1'b0;
  logic [BEAT_W-1:0] in_data_i = '0;
  logic              stall_i = 1'b0;
  logic              in_ready_o;
  logic              wrif_en_o;
  logic [ADDR_W-1:0] wrif_addr_o;
  logic [LINE_W-1:0] wrif_data_o;
  logic              busy_o;
  logic              done_o;

  fetch_ref_line_packer #(
    .BEAT_W(BEAT_W),
    .BEATS (BEATS),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .num_lines_i(num_lines_i),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .stall_i    (stall_i),
    .wrif_en_o  (wrif_en_o),
    .wrif_addr_o(wrif_addr_o),
    .wrif_data_o(wrif_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] base;
    int                num;
    int                stall;   // stall cycles after each line's last beat
    bit                gaps;    // random in_valid_i bubbles
    bit                pat;     // beats 00/11/22/33 pattern
    bit                mid;     // pulse start_i while busy
    int                period;  // expected cycles between writes, 0 = unchecked
    int                ew;      // expected number of writes
    logic [ADDR_W-1:0] last;    // expected last write address
  } vec_t;

  vec_t vecs[8];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [BEAT_W-1:0] sb_q[$];
  int                n_wr, n_done, last_wr_cyc, start_cyc, period_exp;
  int                hits[128];
  logic [ADDR_W-1:0] exp_addr, last_wr_addr, prev_addr;
  logic [LINE_W-1:0] last_wr_data, prev_data;
  logic              prev_stall = 1'b0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called once per cycle at the falling edge.
  task automatic monitor_cycle();
    logic [LINE_W-1:0] exp_line;
    cyc++;
    if (start_i && !busy_o) start_cyc = cyc;
    if (prev_stall) begin
      check("stall_hold_addr", wrif_addr_o, prev_addr);
      check("stall_hold_data", wrif_data_o, prev_data);
    end
    if (stall_i) begin
      check("stall_no_write", wrif_en_o, 1'b0);
      check("stall_no_ready", in_ready_o, 1'b0);
    end
    if (wrif_en_o) begin
      check("wr_addr", wrif_addr_o, exp_addr);
      check("wr_beats_queued", sb_q.size() >= BEATS, 1'b1);
      exp_line = '0;
      if (sb_q.size() >= BEATS) begin
        for (int k = 0; k < BEATS; k++) exp_line[k*BEAT_W +: BEAT_W] = sb_q.pop_front();
      end
      check("wr_data", wrif_data_o, exp_line);
      if (period_exp > 0 && n_wr > 0) check("wr_period", cyc - last_wr_cyc, period_exp);
      hits[wrif_addr_o]++;
      n_wr++;
      last_wr_cyc  = cyc;
      last_wr_addr = wrif_addr_o;
      last_wr_data = wrif_data_o;
      exp_addr     = exp_addr + 1'b1;
    end
    if (done_o) begin
      n_done++;
      check("done_latency", cyc, (n_wr == 0) ? start_cyc + 1 : last_wr_cyc + 1);
      check("done_not_busy", busy_o, 1'b0);
    end
    prev_stall = stall_i;
    prev_addr  = wrif_addr_o;
    prev_data  = wrif_data_o;
  endtask

  task automatic reset_monitor(input logic [ADDR_W-1:0] base, input int period);
    n_wr = 0;
    n_done = 0;
    sb_q.delete();
    for (int i = 0; i < 128; i++) hits[i] = 0;
    exp_addr   = base;
    period_exp = period;
    prev_stall = 1'b0;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_fill(input vec_t v);
    int n, sent, budget, stall_left, not_once;
    bit accepted;
    logic [LINE_W-1:0] exp_pat;
    reset_monitor(v.base, v.period);
    start_i     = 1'b1;
    base_addr_i = v.base;
    num_lines_i = 8'(v.num);
    @(negedge clk); monitor_cycle();
    @(posedge clk); #1;
    start_i     = 1'b0;
    base_addr_i = '0;
    num_lines_i = '0;
    check("busy_after_start", busy_o, v.num != 0);
    n = v.num * BEATS;
    sent = 0;
    budget = 0;
    stall_left = 0;
    while ((sent < n || n_done == 0) && budget < 60 * v.num + 40) begin
      accepted = 1'b0;
      if (v.mid && budget == 3) begin
        start_i     = 1'b1;
        base_addr_i = 7'd90;
        num_lines_i = 8'd5;
      end else begin
        start_i     = 1'b0;
        base_addr_i = '0;
        num_lines_i = '0;
      end
      if (!in_valid_i && sent < n && (!v.gaps || $urandom_range(1, 0) == 1)) begin
        in_valid_i = 1'b1;
        if (v.pat) in_data_i = {16{8'((sent % BEATS) * 17)}};
        else       in_data_i = {$urandom, $urandom, $urandom, $urandom};
      end
      stall_i = (stall_left > 0);
      if (stall_left > 0) stall_left--;
      @(negedge clk); monitor_cycle();
      if (in_valid_i && in_ready_o) begin
        sb_q.push_back(in_data_i);
        sent++;
        accepted = 1'b1;
        if (sent % BEATS == 0) stall_left = v.stall;
      end
      @(posedge clk); #1;
      if (accepted) in_valid_i = 1'b0;
      budget++;
    end
    start_i    = 1'b0;
    stall_i    = 1'b0;
    in_valid_i = 1'b0;
    check("fill_finished", (sent == n) && (n_done > 0), 1'b1);
    repeat (3) begin
      @(negedge clk); monitor_cycle();
      @(posedge clk); #1;
    end
    check("n_writes", n_wr, v.ew);
    check("n_done", n_done, 1);
    check("leftover_beats", sb_q.size(), 0);
    if (v.ew > 0) check("last_addr", last_wr_addr, v.last);
    if (v.num == 128) begin
      not_once = 0;
      for (int i = 0; i < 128; i++) if (hits[i] != 1) not_once++;
      check("addr_once", not_once, 0);
    end
    if (v.pat) begin
      exp_pat = {{16{8'h33}}, {16{8'h22}}, {16{8'h11}}, {16{8'h00}}};
      check("packed_line", last_wr_data, exp_pat);
    end
  endtask

  initial begin
    int sent, guard;
    bit acc;
    //            base     num stall gaps pat mid period ew   last
    vecs[0] = '{7'd5,   1,   0,  1'b0, 1'b1, 1'b0, 0, 1,   7'd5};
    vecs[1] = '{7'd126, 4,   0,  1'b0, 1'b0, 1'b0, 5, 4,   7'd1};
    vecs[2] = '{7'd10,  2,   3,  1'b0, 1'b0, 1'b0, 8, 2,   7'd11};
    vecs[3] = '{7'd0,   0,   0,  1'b0, 1'b0, 1'b0, 0, 0,   7'd0};
    vecs[4] = '{7'd127, 2,   1,  1'b0, 1'b0, 1'b0, 6, 2,   7'd0};
    vecs[5] = '{7'd20,  2,   0,  1'b0, 1'b0, 1'b1, 5, 2,   7'd21};
    vecs[6] = '{7'd3,   3,   2,  1'b1, 1'b0, 1'b0, 0, 3,   7'd5};
    vecs[7] = '{7'd64,  128, 0,  1'b1, 1'b0, 1'b0, 0, 128, 7'd63};

    #1;
    check("reset_ctrl", {in_ready_o, wrif_en_o, busy_o, done_o, wrif_addr_o}, '0);
    check("reset_data", wrif_data_o, '0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    for (int i = 0; i < 8; i++) run_fill(vecs[i]);

    // Asynchronous reset in the middle of the second line of a 3-line fill.
    reset_monitor(7'd40, 0);
    start_i     = 1'b1;
    base_addr_i = 7'd40;
    num_lines_i = 8'd3;
    @(negedge clk); monitor_cycle();
    @(posedge clk); #1;
    start_i     = 1'b0;
    in_valid_i  = 1'b1;
    in_data_i   = {$urandom, $urandom, $urandom, $urandom};
    sent = 0;
    guard = 0;
    while (sent < 6 && guard < 40) begin
      @(negedge clk); monitor_cycle();
      acc = in_ready_o;
      if (acc) begin
        sb_q.push_back(in_data_i);
        sent++;
      end
      @(posedge clk); #1;
      if (acc) in_data_i = {$urandom, $urandom, $urandom, $urandom};
      guard++;
    end
    in_valid_i = 1'b0;
    check("pre_reset_beats", sent, 6);
    check("pre_reset_writes", n_wr, 1);
    #2 rstn = 1'b0;
    #1;
    check("midfill_reset_ctrl", {in_ready_o, wrif_en_o, busy_o, done_o, wrif_addr_o}, '0);
    check("midfill_reset_data", wrif_data_o, '0);
    repeat (2) begin
      @(negedge clk); monitor_cycle();
    end
    @(posedge clk); #1 rstn = 1'b1;
    repeat (8) begin
      @(negedge clk); monitor_cycle();
      @(posedge clk); #1;
    end
    check("post_reset_writes", n_wr, 1);
    check("post_reset_done", n_done, 0);
    check("post_reset_idle", {busy_o, in_ready_o}, '0);

    run_fill(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
